pwm_capture: RTL



---
 rtl/pwm_capture.sv | 202 ++++++++++++++++++++
 1 files changed

// File: rtl/pwm_capture.sv
// rtl/pwm_capture.sv - PWM input decoder: period, high time and 8-bit duty of an external PWM pin
module pwm_capture #(
    parameter int CNT_W       = 24,
    parameter int TIMEOUT_CYC = 2000000
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             ena,
    input  logic             clear,
    input  logic             pwm_in,
    output logic [CNT_W-1:0] period_out,
    output logic [CNT_W-1:0] high_out,
    output logic [7:0]       duty_out,
    output logic             valid,
    output logic             busy,
    output logic             overrun,
    output logic             stuck
);

    localparam logic [CNT_W-1:0] TMO    = CNT_W'(TIMEOUT_CYC);
    localparam logic [CNT_W-1:0] TMO_M1 = CNT_W'(TIMEOUT_CYC - 1);

    typedef enum logic [1:0] {
        IDLE,
        MEAS,
        DIV,
        TOUT
    } state_t;

    state_t           state;
    state_t           state_nx;

    logic             s1;
    logic             s2;
    logic             s3;
    logic             rise;
    logic             fall;
    logic             restart;
    logic             tmo_hit;
    logic             div_last;

    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] hi_lat;
    logic [CNT_W-1:0] div_p;
    logic [CNT_W-1:0] div_h;
    logic [CNT_W-1:0] rem;
    logic [6:0]       quo;
    logic [2:0]       idx;

    logic [CNT_W:0]   rem_sh;
    logic [CNT_W-1:0] rem_nx;
    logic             ge;

    // The synchronizer keeps sampling through enable/clear so no edge is lost on restart.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1 <= 1'b0;
            s2 <= 1'b0;
            s3 <= 1'b0;
        end else begin
            s1 <= pwm_in;
            s2 <= s1;
            s3 <= s2;
        end
    end

    assign rise     = s2 & ~s3;
    assign fall     = ~s2 & s3;
    assign restart  = ~ena | clear;
    assign tmo_hit  = (cnt == TMO_M1);
    assign div_last = (idx == 3'd0);
    assign busy     = (state == DIV);

    // rem stays below period after every step, so CNT_W bits hold it; only the shifted value needs the extra bit.
    assign rem_sh = {rem, 1'b0};
    assign ge     = (rem_sh >= {1'b0, div_p});
    assign rem_nx = ge ? (rem_sh[CNT_W-1:0] - div_p) : rem_sh[CNT_W-1:0];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nx;
        end
    end

    always_comb begin
        state_nx = state;
        case (state)
            IDLE: begin
                if (rise) begin
                    state_nx = MEAS;
                end else if (tmo_hit) begin
                    state_nx = TOUT;
                end
            end
            MEAS: begin
                if (rise) begin
                    state_nx = DIV;
                end else if (tmo_hit) begin
                    state_nx = TOUT;
                end
            end
            DIV: begin
                if (div_last) begin
                    state_nx = MEAS;
                end
            end
            TOUT: begin
                state_nx = IDLE;
            end
            default: begin
                state_nx = IDLE;
            end
        endcase
        if (restart) begin
            state_nx = IDLE;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt        <= '0;
            hi_lat     <= '0;
            div_p      <= '0;
            div_h      <= '0;
            rem        <= '0;
            quo        <= '0;
            idx        <= '0;
            period_out <= '0;
            high_out   <= '0;
            duty_out   <= '0;
            valid      <= 1'b0;
            overrun    <= 1'b0;
            stuck      <= 1'b0;
        end else if (restart) begin
            cnt        <= '0;
            hi_lat     <= '0;
            div_p      <= '0;
            div_h      <= '0;
            rem        <= '0;
            quo        <= '0;
            idx        <= '0;
            period_out <= '0;
            high_out   <= '0;
            duty_out   <= '0;
            valid      <= 1'b0;
            overrun    <= 1'b0;
            stuck      <= 1'b0;
        end else begin
            valid <= 1'b0;

            // Counter restarts on every rise, so the next period is measured while dividing.
            if (rise) begin
                cnt <= '0;
            end else if (cnt != TMO) begin
                cnt <= cnt + 1'b1;
            end

            if (fall) begin
                hi_lat <= cnt + 1'b1;
            end

            case (state)
                MEAS: begin
                    if (rise) begin
                        div_p <= cnt + 1'b1;
                        div_h <= hi_lat;
                        rem   <= hi_lat;
                        quo   <= '0;
                        idx   <= 3'd7;
                    end
                end
                DIV: begin
                    rem <= rem_nx;
                    quo <= {quo[5:0], ge};
                    idx <= idx - 3'd1;
                    if (rise) begin
                        overrun <= 1'b1;
                    end
                    if (div_last) begin
                        period_out <= div_p;
                        high_out   <= div_h;
                        duty_out   <= {quo, ge};
                        stuck      <= 1'b0;
                        valid      <= 1'b1;
                    end
                end
                TOUT: begin
                    period_out <= '0;
                    high_out   <= '0;
                    duty_out   <= s2 ? 8'hFF : 8'h00;
                    stuck      <= 1'b1;
                    valid      <= 1'b1;
                end
                default: begin
                end
            endcase
        end
    end

endmodule
